read_write_enable_fifo: RTL and testbench



---
 rtl/read_write_enable_fifo_pkg.sv | 8 +
 rtl/read_write_enable_fifo_if.sv | 21 ++
 rtl/read_write_enable_fifo_wrap_pointer.sv | 24 ++
 rtl/read_write_enable_fifo.sv | 36 +++
 tb/tb_read_write_enable_fifo.sv | 83 ++++++++
 5 files changed

// File: rtl/read_write_enable_fifo_pkg.sv
// read_write_enable_fifo_pkg: shared defaults and index-width helper for the FIFO slice
package read_write_enable_fifo_pkg;
  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 4;
  function automatic int index_bits(input int depth);
    return depth > 1 ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/read_write_enable_fifo_if.sv
// read_write_enable_fifo_if: write/read enable handshake bundle between a client and the FIFO
interface read_write_enable_fifo_if
  import read_write_enable_fifo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             write_enable;
  logic [WIDTH-1:0] write_data;
  logic             full;
  logic             read_enable;
  logic [WIDTH-1:0] read_data;
  logic             empty;
  modport master (
    output write_enable, write_data, read_enable,
    input  full, read_data, empty
  );
  modport slave (
    input  write_enable, write_data, read_enable,
    output full, read_data, empty
  );
endinterface

// File: rtl/read_write_enable_fifo_wrap_pointer.sv
// wrap_pointer: modulo-DEPTH index with a lap bit that toggles on every wrap
module wrap_pointer
  import read_write_enable_fifo_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         increment,
  output logic [index_bits(DEPTH)-1:0] index,
  output logic                         lap
);
  localparam int IW = index_bits(DEPTH);
  localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);
  always_ff @(posedge clock) begin
    if (reset) begin
      index <= '0;
      lap   <= 1'b0;
    end else if (increment) begin
      index <= index == LAST ? '0 : index + 1'b1;
      lap   <= index == LAST ? ~lap : lap;
    end
  end
endmodule

// File: rtl/read_write_enable_fifo.sv
// read_write_enable_fifo: single-clock first-word fall-through FIFO with enable handshakes
module read_write_enable_fifo
  import read_write_enable_fifo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input logic                   clock,
  input logic                   reset,
  read_write_enable_fifo_if.slave bus
);
  localparam int IW = index_bits(DEPTH);
  logic [IW-1:0]    w_idx, r_idx;
  logic             w_lap, r_lap;
  logic             do_write, do_read;
  logic [WIDTH-1:0] mem [DEPTH];
  // Equal indices mean empty or full; the lap bits tell which.
  assign bus.empty    = w_idx == r_idx && w_lap == r_lap;
  assign bus.full     = w_idx == r_idx && w_lap != r_lap;
  assign bus.read_data = mem[r_idx];
  assign do_write     = bus.write_enable && !bus.full;
  assign do_read      = bus.read_enable && !bus.empty;
  wrap_pointer #(.DEPTH(DEPTH)) u_wr (
    .clock(clock), .reset(reset), .increment(do_write), .index(w_idx), .lap(w_lap)
  );
  wrap_pointer #(.DEPTH(DEPTH)) u_rd (
    .clock(clock), .reset(reset), .increment(do_read), .index(r_idx), .lap(r_lap)
  );
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_write) begin
      mem[w_idx] <= bus.write_data;
    end
  end
endmodule

// File: tb/tb_read_write_enable_fifo.sv
// tb_read_write_enable_fifo: directed and random scoreboard bench for the FWFT FIFO
module tb_read_write_enable_fifo;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] q [$];
  read_write_enable_fifo_if #(.WIDTH(WIDTH)) bus ();
  read_write_enable_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic check_flags(input string tag);
    check({tag, "_empty"}, 32'(bus.empty), 32'(q.size() == 0));
    check({tag, "_full"}, 32'(bus.full), 32'(q.size() == DEPTH));
    if (q.size() > 0) check({tag, "_head"}, 32'(bus.read_data), 32'(q[0]));
  endtask
  task automatic cycle(input logic w, input logic [WIDTH-1:0] d, input logic r, input string tag);
    bit full_m;
    full_m = q.size() == DEPTH;
    bus.write_enable = w;
    bus.write_data   = d;
    bus.read_enable  = r;
    if (r && q.size() > 0) check({tag, "_rd"}, 32'(bus.read_data), 32'(q.pop_front()));
    if (w && !full_m) q.push_back(d);
    @(posedge clock);
    #1;
    bus.write_enable = 1'b0;
    bus.read_enable  = 1'b0;
    check_flags(tag);
  endtask
  task automatic do_reset(input logic w, input logic r);
    reset = 1'b1;
    bus.write_enable = w;
    bus.write_data   = 8'hEE;
    bus.read_enable  = r;
    @(posedge clock);
    #1;
    reset = 1'b0;
    bus.write_enable = 1'b0;
    bus.read_enable  = 1'b0;
    q.delete();
    check("rst_empty", 32'(bus.empty), 32'd1);
    check("rst_full", 32'(bus.full), 32'd0);
    check("rst_data", 32'(bus.read_data), 32'd0);
  endtask
  initial begin
    bus.write_enable = 1'b0;
    bus.write_data   = '0;
    bus.read_enable  = 1'b0;
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, WIDTH'($urandom), 1'b0, "fill");
    cycle(1'b1, 8'h33, 1'b0, "wr_full");
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, '0, 1'b1, "drain");
    cycle(1'b0, '0, 1'b1, "rd_empty");
    cycle(1'b1, 8'd0, 1'b0, "stream");
    for (int i = 1; i < 100; i++) cycle(1'b1, WIDTH'(i), 1'b1, "stream");
    cycle(1'b0, '0, 1'b1, "stream_end");
    for (int i = 0; i < 100; i++)
      cycle(1'($urandom_range(0, 1)), WIDTH'($urandom), 1'($urandom_range(0, 1)), "rand");
    while (q.size() > 0) cycle(1'b0, '0, 1'b1, "rand_drain");
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, WIDTH'(8'h10 + i), 1'b0, "fill2");
    cycle(1'b1, 8'hAA, 1'b1, "full_rw");
    for (int i = 0; i < DEPTH - 1; i++) cycle(1'b0, '0, 1'b1, "after_rw");
    check("after_rw_empty", 32'(bus.empty), 32'd1);
    cycle(1'b1, 8'h77, 1'b1, "empty_rw");
    cycle(1'b1, 8'h01, 1'b0, "pre_rst");
    do_reset(1'b1, 1'b1);
    cycle(1'b1, 8'h5C, 1'b0, "post_rst");
    cycle(1'b0, '0, 1'b1, "post_rst");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
